// File: rtl/muldiv_iter.sv
// muldiv_iter: iterative MULT/MADD/MSUB/DIV unit with start/ready handshake and annul.
// Define MULDIV_FAST_MUL_EN to replace the shift-add multiply with a combinational multiplier.
module muldiv_iter #(
    parameter int W = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start_i,
    input  logic [2:0]     op_i,
    input  logic [W-1:0]   opa_i,
    input  logic [W-1:0]   opb_i,
    input  logic [2*W-1:0] acc_i,
    input  logic           annul_i,
    output logic           busy_o,
    output logic           ready_o,
    output logic [2*W-1:0] result_o,
    output logic           div_by_zero_o
);
    localparam int CW = $clog2(W + 1);
    typedef enum logic [2:0] {IDLE, MUL, DIV, FIN, DONE} state_t;
`ifdef MULDIV_FAST_MUL_EN
    localparam state_t MUL_ST = FIN;
`else
    localparam state_t MUL_ST = MUL;
`endif
    state_t state;
    logic [CW-1:0] cnt;
    logic [2:0] op;
    logic [W-1:0] a, b, abs_a, abs_b;
    logic sa, sb, dbz, sign_a, sign_b, is_div, zero_div, go;
    logic [2*W-1:0] acc, p, p_init, mp, prod, mres, dres;
    logic [W:0] dt, ddiff;
`ifndef MULDIV_FAST_MUL_EN
    logic [W:0] msum;
    assign msum = {1'b0, p[2*W-1:W]} + {1'b0, p[0] ? a : {W{1'b0}}};
`endif
    always_comb begin
        go = (state == IDLE || state == DONE) && start_i && !annul_i;
        sign_a = op_i[0] & opa_i[W-1];
        sign_b = op_i[0] & opb_i[W-1];
        abs_a = sign_a ? -opa_i : opa_i;
        abs_b = sign_b ? -opb_i : opb_i;
        is_div = op_i[2:1] == 2'b11;
        zero_div = is_div && opb_i == '0;
        // divide-by-zero result is preloaded so FIN only has to pass it through
        p_init = zero_div ? {opa_i, {W{1'b1}}} : {{W{1'b0}}, is_div ? abs_a : abs_b};
        dt = p[2*W-1:W-1];
        ddiff = dt - {1'b0, b};
`ifdef MULDIV_FAST_MUL_EN
        mp = {{W{1'b0}}, a} * {{W{1'b0}}, b};
`else
        mp = p;
`endif
        prod = (sa ^ sb) ? -mp : mp;
        mres = op[2:1] == 2'b01 ? acc + prod : op[2:1] == 2'b10 ? acc - prod : prod;
        dres = dbz ? p : {sa ? -p[2*W-1:W] : p[2*W-1:W], (sa ^ sb) ? -p[W-1:0] : p[W-1:0]};
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            op <= '0;
            a <= '0;
            b <= '0;
            sa <= 1'b0;
            sb <= 1'b0;
            dbz <= 1'b0;
            acc <= '0;
            p <= '0;
            busy_o <= 1'b0;
            ready_o <= 1'b0;
            result_o <= '0;
            div_by_zero_o <= 1'b0;
        end else begin
            ready_o <= 1'b0;
            if (annul_i && busy_o) begin
                state <= IDLE;
                busy_o <= 1'b0;
            end else begin
                case (state)
`ifndef MULDIV_FAST_MUL_EN
                    MUL: begin
                        p <= {msum, p[W-1:1]};
                        cnt <= cnt - 1'b1;
                        state <= cnt == CW'(1) ? FIN : MUL;
                    end
`endif
                    DIV: begin
                        p <= {ddiff[W] ? dt[W-1:0] : ddiff[W-1:0], p[W-2:0], ~ddiff[W]};
                        cnt <= cnt - 1'b1;
                        state <= cnt == CW'(1) ? FIN : DIV;
                    end
                    FIN: begin
                        result_o <= op[2:1] == 2'b11 ? dres : mres;
                        div_by_zero_o <= dbz;
                        ready_o <= 1'b1;
                        busy_o <= 1'b0;
                        state <= DONE;
                    end
                    default: begin
                        state <= IDLE;
                        if (go) begin
                            op <= op_i;
                            a <= abs_a;
                            b <= abs_b;
                            sa <= sign_a;
                            sb <= sign_b;
                            dbz <= zero_div;
                            acc <= acc_i;
                            p <= p_init;
                            cnt <= CW'(W);
                            busy_o <= 1'b1;
                            state <= is_div ? (zero_div ? FIN : DIV) : MUL_ST;
                        end
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_muldiv_iter.sv
// tb_muldiv_iter: directed checks of muldiv_iter at W=32 (latency follows MULDIV_FAST_MUL_EN).
module tb_muldiv_iter;
    logic clk = 1'b0, rst = 1'b1, start_i = 1'b0, annul_i = 1'b0;
    logic [2:0] op_i = '0;
    logic [31:0] opa_i = '0, opb_i = '0;
    logic [63:0] acc_i = '0, result_o, prev;
    logic busy_o, ready_o, div_by_zero_o;
`ifdef MULDIV_FAST_MUL_EN
    localparam int LAT = 2, BC = 1, ANN = 1;
`else
    localparam int LAT = 34, BC = 33, ANN = 10;
`endif
    localparam int DLAT = 34;
    int total = 0, fails = 0, n, bc, pulses;

    muldiv_iter #(.W(32)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i), .opa_i(opa_i), .opb_i(opb_i),
        .acc_i(acc_i), .annul_i(annul_i), .busy_o(busy_o), .ready_o(ready_o),
        .result_o(result_o), .div_by_zero_o(div_by_zero_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input logic [63:0] c);
        @(negedge clk);
        start_i = 1'b1;
        op_i = o;
        opa_i = x;
        opb_i = y;
        acc_i = c;
    endtask

    task automatic wait_rdy(input bit keep, output int cyc, output int bsy);
        cyc = 0;
        bsy = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (!keep) start_i = 1'b0;
            bsy += int'(busy_o);
        end while (!ready_o && cyc < 200);
    endtask

    task automatic run(input string tag, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [63:0] c, input logic [63:0] exp, input int lat);
        issue(o, x, y, c);
        wait_rdy(1'b0, n, bc);
        chk({tag, "_lat"}, 64'(n), 64'(lat));
        chk(tag, result_o, exp);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_ready", 64'(ready_o), 64'd0);
        chk("rst_result", result_o, 64'd0);
        chk("rst_dbz", 64'(div_by_zero_o), 64'd0);
        rst = 1'b0;

        issue(3'd1, 32'hFFFFFFFD, 32'd7, 64'd0);
        wait_rdy(1'b0, n, bc);
        chk("mult_lat", 64'(n), 64'(LAT));
        chk("mult_busy_cycles", 64'(bc), 64'(BC));
        chk("mult", result_o, 64'hFFFFFFFF_FFFFFFEB);
        @(negedge clk);
        chk("ready_one_cycle", 64'(ready_o), 64'd0);
        chk("result_hold", result_o, 64'hFFFFFFFF_FFFFFFEB);

        run("maddu", 3'd2, 32'hFFFFFFFF, 32'd2, 64'h00000001_FFFFFFFF, 64'h00000003_FFFFFFFD, LAT);
        run("msub", 3'd5, 32'd2, 32'd3, 64'd0, 64'hFFFFFFFF_FFFFFFFA, LAT);

        run("div_neg", 3'd7, 32'hFFFFFFF9, 32'd2, 64'd0, 64'hFFFFFFFF_FFFFFFFD, DLAT);
        run("div_ovf", 3'd7, 32'h80000000, 32'hFFFFFFFF, 64'd0, 64'h00000000_80000000, DLAT);
        run("divu", 3'd6, 32'hFFFFFFFF, 32'h10, 64'd0, 64'h0000000F_0FFFFFFF, DLAT);

        run("div0", 3'd6, 32'h00001234, 32'd0, 64'd0, 64'h00001234_FFFFFFFF, 2);
        chk("div0_flag", 64'(div_by_zero_o), 64'd1);
        run("divu_after0", 3'd6, 32'd100, 32'd7, 64'd0, 64'h00000002_0000000E, DLAT);
        chk("div0_flag_clear", 64'(div_by_zero_o), 64'd0);

        prev = result_o;
        issue(3'd0, 32'h12345, 32'h777, 64'd0);
        repeat (ANN) begin
            @(negedge clk);
            start_i = 1'b0;
        end
        annul_i = 1'b1;
        @(negedge clk);
        chk("annul_busy", 64'(busy_o), 64'd0);
        chk("annul_ready", 64'(ready_o), 64'd0);
        chk("annul_result", result_o, prev);
        start_i = 1'b1;
        @(negedge clk);
        chk("annul_beats_start", 64'(busy_o), 64'd0);
        start_i = 1'b0;
        annul_i = 1'b0;
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            pulses += int'(ready_o);
        end
        chk("annul_no_ready", 64'(pulses), 64'd0);
        chk("annul_result_kept", result_o, prev);

        issue(3'd6, 32'd100, 32'd7, 64'd0);
        repeat (3) begin
            @(negedge clk);
            start_i = 1'b0;
        end
        chk("div_running", 64'(busy_o), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy", 64'(busy_o), 64'd0);
        chk("midrst_ready", 64'(ready_o), 64'd0);
        chk("midrst_result", result_o, 64'd0);
        chk("midrst_dbz", 64'(div_by_zero_o), 64'd0);
        rst = 1'b0;

        issue(3'd6, 32'd1000, 32'd10, 64'd0);
        wait_rdy(1'b1, n, bc);
        chk("b2b_first_lat", 64'(n), 64'(DLAT));
        chk("b2b_first", result_o, 64'h00000000_00000064);
        opa_i = 32'd77;
        opb_i = 32'd5;
        wait_rdy(1'b0, n, bc);
        chk("b2b_gap", 64'(n), 64'(DLAT));
        chk("b2b_second", result_o, 64'h00000002_0000000F);

        issue(3'd0, 32'd3, 32'd5, 64'd0);
        @(negedge clk);
        op_i = 3'd6;
        opa_i = 32'd9;
        opb_i = 32'd3;
        wait_rdy(1'b0, n, bc);
        chk("busy_start_lat", 64'(n + 1), 64'(LAT));
        chk("busy_start_ignored", result_o, 64'd15);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule

// File: doc/muldiv_iter.md
# muldiv_iter

Iterative multiply/divide unit for the EX stage. It executes MULT/MULTU, MADD/MADDU, MSUB/MSUBU and DIV/DIVU on parametrised-width operands and returns a 2W-bit {HI,LO} result. Handshake is start/ready. EX holds `stallreq_from_ex` high while `busy_o` is set and writes the result to HI/LO on `ready_o`. It replaces the separate two-cycle MADD/MSUB sequencing and the external divider with one annul-able unit.

## Interface
- W, 32, operand width; W ≥ 4, power of two.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- start_i  in  1  request. Sampled only in IDLE or DONE.
- op_i  in  3  operation code:
  - 0 MULTU, 1 MULT, 2 MADDU, 3 MADD, 4 MSUBU, 5 MSUB, 6 DIVU, 7 DIV.
  - bit0 = signed.
- opa_i  in  W  multiplicand / dividend.
- opb_i  in  W  multiplier / divisor.
- acc_i  in  2W  forwarded {HI,LO} accumulator for MADD*/MSUB*.
- annul_i  in  1  abort the current operation (pipeline flush).
- busy_o  out  1  operation in progress.
- ready_o  out  1  one-cycle pulse: result_o is valid.
- result_o  out  2W  {hi,lo} result.
  - Multiply ops: the product, or acc ± product.
  - Divide ops: {remainder, quotient}.
- div_by_zero_o  out  1  set with ready_o when a divide had opb = 0.

## Operation
- **States:** IDLE, MUL, DIV, FIN, DONE. An iteration counter of $clog2(W+1) bits counts down from W.
- **Accept:** in IDLE or DONE with start_i=1 and annul_i=0.
  - Latches op, |opa| and |opb|, the sign flags, and acc_i.
  - Absolute value is taken only when op bit0=1 and the MSB is set.
- **Multiply (MUL):** one shift-add per cycle, W cycles.
- **FIN for multiply ops:**
  - Negate the product if the operand signs differ (signed ops only).
  - MADD*: add to acc. MSUB*: subtract from acc.
  - Arithmetic is modulo 2^(2W).
- **Divide (DIV):** one restoring-division step per cycle, W cycles.
- **FIN for divide ops:**
  - Quotient is negated if the signs differ.
  - Remainder takes the sign of the dividend.
  - Signed divide only.
- **Divide overflow:** DIV of -2^(W-1) by -1 gives quotient 0x8..0 and remainder 0. No flag.
- **Divide by zero:** accept goes directly to FIN, skipping iterations.
  - Result is hi=opa_i, lo=all ones.
  - div_by_zero_o=1.
- **DONE:**
  - ready_o=1 for exactly one cycle, then the state returns to IDLE.
  - result_o holds until the next accepted start.
  - div_by_zero_o holds with result_o.
- **busy_o:** 1 in MUL, DIV and FIN; 0 in IDLE and DONE.
- **Ignored start:** start_i while busy is ignored.
- **annul_i:**
  - In MUL, DIV or FIN, the next edge goes to IDLE. No ready_o pulse; result_o is unchanged.
  - In IDLE or DONE, annul_i blocks acceptance; annul beats a simultaneous start.
- **Reset values:** state IDLE, counter 0, busy_o=0, ready_o=0, result_o=0, div_by_zero_o=0, all internal registers 0.
- **Reset mid-operation:** reset has the same effect as annul, and also clears result_o.

## Timing
- E0 = the edge on which start is accepted.
- Iterative multiply and divide: MUL/DIV from E0 to E0+W; FIN after E0+W; DONE after E0+W+1.
  - ready_o is high in the cycle following edge E0+W+1, which is W+2 cycles from start.
- Divide by zero: FIN after E0, DONE after E0+1.
- Back-to-back issue: start_i may be asserted in the DONE cycle and is accepted at that edge.
- acc_i is sampled only at E0. EX must present forwarded HI/LO in the start cycle.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- **MULDIV_FAST_MUL_EN defined:**
  - Multiply ops go from accept straight to FIN.
  - The product is formed by a single combinational W×W multiplier on the latched operands.
  - ready_o is high after E0+1 (2-cycle latency).
  - The MUL state and its shift-add datapath are not built.
  - Divide is unchanged.
- **MULDIV_FAST_MUL_EN undefined:** iterative shift-add multiply, W+2-cycle latency.

## Test plan
All scenarios use W=32.
1. MULT opa=0xFFFFFFFD, opb=7.
   - Required: result_o=0xFFFFFFFF_FFFFFFEB.
   - ready_o 34 cycles after start (2 with MULDIV_FAST_MUL_EN).
   - busy_o high for exactly 33 cycles.
2. MADDU acc=0x00000001_FFFFFFFF, opa=0xFFFFFFFF, opb=2.
   - Required: result_o=0x00000003_FFFFFFFD.
   - Also: MSUB acc=0, opa=2, opb=3 gives result_o=0xFFFFFFFF_FFFFFFFA.
3. DIV opa=0xFFFFFFF9, opb=2.
   - Required: {hi,lo}={0xFFFFFFFF, 0xFFFFFFFD}.
   - Also: DIV 0x80000000 / 0xFFFFFFFF gives {0x00000000, 0x80000000}.
   - Also: DIVU 0xFFFFFFFF / 0x10 gives {0x0000000F, 0x0FFFFFFF}.
4. DIVU opa=0x00001234, opb=0.
   - Required: ready_o after edge E0+1.
   - result_o={0x00001234, 0xFFFFFFFF}, div_by_zero_o=1.
   - The next non-zero divide clears div_by_zero_o.
5. Annul and reset during an operation.
   - Start MULTU, then assert annul_i in the 10th MUL cycle.
   - Required: busy_o=0 next cycle, no ready_o, result_o keeps its previous value.
   - A start in the same cycle as annul in IDLE is not accepted.
   - rst during DIV: all outputs 0 next cycle.
6. Back-to-back issue and busy start.
   - Two DIVU ops back-to-back, with start held high through the DONE cycle.
   - Required: the second op is accepted at the DONE edge.
   - ready_o pulses are 34 cycles apart.
   - A start pulse while busy has no effect.
